// File: rtl/biu_rsp_pack.sv
// Packs bus read beats into one response line, flagging short, long or errored bursts.
// Bursts longer than one line are truncated: the overflow beats are dropped up to rlast.
module biu_rsp_pack #(
  parameter int unsigned BEAT_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_rvalid,
  output logic                  bus_rready,
  input  logic [BEAT_WIDTH-1:0] bus_rdata,
  input  logic                  bus_rlast,
  input  logic                  bus_rerr,
  output logic                  biu_rsp_valid,
  input  logic                  biu_rsp_ready,
  output logic [LINE_WIDTH-1:0] biu_rsp_rdata,
  output logic                  biu_rsp_err
);

  localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [LINE_WIDTH-1:0] line;
  logic                  err;
  logic                  to_discard;

  // Handshake outputs are straight decodes of the state register.
  assign bus_rready    = (state != HOLD);
  assign biu_rsp_valid = (state == HOLD);
  assign biu_rsp_rdata = line;
  assign biu_rsp_err   = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      cnt        <= '0;
      line       <= '0;
      err        <= 1'b0;
      to_discard <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus_rvalid) begin
            for (int k = 0; k < int'(BEATS); k++) begin
              if (cnt == CW'(k)) line[k*BEAT_WIDTH +: BEAT_WIDTH] <= bus_rdata;
            end
            if (bus_rlast || (cnt == LAST_BEAT)) begin
              // Clean only if rlast lands exactly on the final lane.
              state      <= HOLD;
              cnt        <= '0;
              err        <= err | bus_rerr | ~(bus_rlast & (cnt == LAST_BEAT));
              to_discard <= ~bus_rlast;
            end else begin
              cnt <= cnt + CW'(1);
              err <= err | bus_rerr;
            end
          end
        end
        HOLD: begin
          if (biu_rsp_ready) begin
            state      <= to_discard ? DISCARD : COLLECT;
            line       <= '0;
            err        <= 1'b0;
            to_discard <= 1'b0;
          end
        end
        DISCARD: begin
          if (bus_rvalid && bus_rlast) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/biu_rsp_pack.md
BIU_RSP_PACK -- requirements
Module: biu_rsp_pack

Interface
REQ-001 SHALL have parameter BEAT_WIDTH, default 32, bus read-data beat width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, packed response width; BEATS = LINE_WIDTH/BEAT_WIDTH (default 4, power of two, >=2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bus_rvalid  input  1  bus read beat valid.
REQ-007 bus_rready  output  1  block accepts beat.
REQ-008 bus_rdata  input  BEAT_WIDTH  beat data.
REQ-009 bus_rlast  input  1  final beat of burst.
REQ-010 bus_rerr  input  1  beat carries slave error.
REQ-011 biu_rsp_valid  output  1  packed line valid to response FIFO.
REQ-012 biu_rsp_ready  input  1  response FIFO accepts line.
REQ-013 biu_rsp_rdata  output  LINE_WIDTH  packed line.
REQ-014 biu_rsp_err  output  1  line error flag, qualified by biu_rsp_valid.

Function
REQ-015 SHALL implement states COLLECT, HOLD, DISCARD.
REQ-016 Beat transfer SHALL occur when bus_rvalid && bus_rready at a rising edge; line transfer when biu_rsp_valid && biu_rsp_ready.
REQ-017 bus_rready SHALL be combinationally 1 in COLLECT and DISCARD, 0 in HOLD.
REQ-018 biu_rsp_valid SHALL be 1 exactly in HOLD.
REQ-019 In COLLECT, beat k (counter 0..BEATS-1) SHALL be written to lane k, bits [k*BEAT_WIDTH +: BEAT_WIDTH]; counter increments per beat.
REQ-020 Line SHALL complete on the beat with bus_rlast=1 or on beat BEATS-1, whichever first; next state HOLD, counter cleared.
REQ-021 Early rlast (counter < BEATS-1): unwritten lanes SHALL be zero; biu_rsp_err SHALL be 1.
REQ-022 Beat BEATS-1 with bus_rlast=0: line completes, biu_rsp_err=1, and after HOLD the FSM SHALL enter DISCARD, not COLLECT.
REQ-023 biu_rsp_err SHALL also be 1 if any beat of the line had bus_rerr=1 (sticky OR, cleared when line transfers).
REQ-024 Latency: biu_rsp_valid SHALL rise the cycle after the completing beat transfers.
REQ-025 In HOLD, biu_rsp_rdata and biu_rsp_err SHALL stay stable until line transfer; transfer returns FSM to COLLECT (or DISCARD per REQ-022) next cycle.
REQ-026 In DISCARD, beats SHALL be accepted and dropped; bus_rlast beat returns to COLLECT; no line produced.
REQ-027 In DISCARD, bus_rerr on dropped beats SHALL be ignored.
REQ-028 biu_rsp_ready while not in HOLD SHALL have no effect.
REQ-029 Lanes SHALL be zeroed at start of each line (after line transfer) so stale data never appears.
REQ-030 Single-beat burst (rlast on beat 0) SHALL yield lane 0 = data, others 0, err=1.

Reset
REQ-031 rst=1 SHALL force COLLECT, counter 0, line register 0, err 0; hence biu_rsp_valid=0, biu_rsp_rdata=0, biu_rsp_err=0, bus_rready=1 after the edge.
REQ-032 rst during COLLECT, HOLD or DISCARD SHALL drop any partial or held line; a beat presented in the reset cycle SHALL NOT be captured.
REQ-033 rst SHALL take priority over all concurrent transfers.

Verification
REQ-034 4 beats 0x11111111,0x22222222,0x33333333,0x44444444, rlast on 4th, ready=1 -> one line 0x44444444_33333333_22222222_11111111, err=0, valid next cycle after beat 4.
REQ-035 2 beats 0xA,0xB with rlast on 2nd -> line 0x0..0_0000000B_0000000A, err=1.
REQ-036 6-beat burst, rlast on 6th -> one line of beats 1-4, err=1, beats 5-6 dropped, next burst packs normally.
REQ-037 biu_rsp_ready=0 for 5 cycles during HOLD with bus_rvalid=1 -> bus_rready=0, data/err stable, no beat lost; line transfers when ready=1.
REQ-038 bus_rerr=1 on beat 2 of 4 -> line data intact, err=1; next clean line err=0.
REQ-039 rst asserted after 2 beats -> valid stays 0, outputs 0; following 4-beat burst produces only its own data.
